// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// seq_det_sched : round-robin scheduler sharing one serial "0110" Mealy
//                 detector between NREQ parallel requesters.
// Optional feature macro: SEQ_DET_IRQ_EN (adds irq_clr / sticky irq).
// Revision      : 1.0
// ============================================================================
module seq_det_sched #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       data,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    z_mon
`ifdef SEQ_DET_IRQ_EN
    ,
    input  logic                    irq_clr,
    output logic                    irq
`endif
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int BIT_W = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } det_t;

    state_t           r_state, w_state_next;
    det_t             r_det, w_det_next;
    logic [ID_W-1:0]  r_g, r_last, r_done_id, w_grant;
    logic [W-1:0]     r_shift, w_word;
    logic [BIT_W-1:0] r_bitcnt;
    logic [CNT_W-1:0] r_frame_cnt, r_match_cnt, w_cnt_next;
    logic [NREQ-1:0]  w_onehot, w_req_rot;
    logic [ID_W:0]    w_sum;
    logic             w_found, w_req_g, w_x, w_z, w_last_bit;

    // Rotate requests so bit 0 is the requester right after the last grant.
    always_comb begin
        w_req_rot = NREQ'({req, req} >> ({1'b0, r_last} + (ID_W+1)'(1)));
        w_found   = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_last} + (ID_W+1)'(k + 1);
            end
        end
        if (w_sum >= (ID_W+1)'(NREQ)) begin
            w_sum = w_sum - (ID_W+1)'(NREQ);
        end
        w_grant = w_sum[ID_W-1:0];
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_g == ID_W'(i)) begin
                w_word = data[i*W +: W];
            end
        end
    end

    assign w_onehot   = NREQ'(1) << r_g;
    assign w_req_g    = |(req & w_onehot);
    assign w_x        = r_shift[W-1];
    assign w_last_bit = (r_bitcnt == BIT_W'(W-1));
    assign w_cnt_next = (w_z && (r_frame_cnt != '1)) ? r_frame_cnt + CNT_W'(1) : r_frame_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_det   <= D0;
        end else begin
            r_state <= w_state_next;
            r_det   <= w_det_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_det_next   = r_det;
        w_z          = 1'b0;
        ack          = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_req_g) begin
                    ack          = w_onehot;
                    w_det_next   = D0;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                case (r_det)
                    D0: w_det_next = w_x ? D0 : D1;
                    D1: w_det_next = w_x ? D2 : D1;
                    D2: w_det_next = w_x ? D3 : D1;
                    D3: begin
                        w_det_next = w_x ? D0 : D1;
                        w_z        = !w_x;
                    end
                endcase
                if (w_last_bit) w_state_next = ST_REPORT;
            end
            ST_REPORT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_g         <= '0;
            r_last      <= ID_W'(NREQ-1);
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_frame_cnt <= '0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) r_g <= w_grant;
                end
                ST_LOAD: begin
                    if (w_req_g) begin
                        r_shift     <= w_word;
                        r_bitcnt    <= '0;
                        r_frame_cnt <= '0;
                        r_last      <= r_g;
                    end
                end
                ST_SHIFT: begin
                    r_shift     <= {r_shift[W-2:0], 1'b0};
                    r_bitcnt    <= r_bitcnt + BIT_W'(1);
                    r_frame_cnt <= w_cnt_next;
                    // Result registers update on the last bit so REPORT sees the final count.
                    if (w_last_bit) begin
                        r_match_cnt <= w_cnt_next;
                        r_done_id   <= r_g;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_REPORT);
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;
    assign z_mon     = w_z;

`ifdef SEQ_DET_IRQ_EN
    logic r_irq;

    // Set has priority over irq_clr; clr clears unconditionally.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_irq <= 1'b0;
        end else if (done && (r_match_cnt != '0)) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// tb_seq_det_sched : scoreboard bench for seq_det_sched with a window-based
// pattern model and a round-robin grant model; a CNT_W=1 copy checks saturation.
module tb_seq_det_sched;
    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int ID_W  = $clog2(NREQ);
    localparam int TMO   = 200;

    logic                  clk;
    logic                  clr;
    logic [NREQ-1:0]       req;
    logic [NREQ*W-1:0]     data;
    logic                  tb_req  [NREQ];
    logic [W-1:0]          tb_data [NREQ];

    logic [NREQ-1:0]       ack, ack_s;
    logic                  busy, busy_s, done, done_s, z_mon, z_mon_s;
    logic [ID_W-1:0]       done_id, done_id_s;
    logic [CNT_W-1:0]      match_cnt;
    logic [0:0]            match_cnt_s;
`ifdef SEQ_DET_IRQ_EN
    logic                  tb_irq_clr, irq, irq_s;
    bit                    exp_irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always_comb begin
        req  = '0;
        data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]          = tb_req[i];
            data[i*W +: W]  = tb_data[i];
        end
    end

    seq_det_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .clr(clr), .req(req), .data(data), .ack(ack), .busy(busy),
        .done(done), .done_id(done_id), .match_cnt(match_cnt), .z_mon(z_mon)
`ifdef SEQ_DET_IRQ_EN
        , .irq_clr(tb_irq_clr), .irq(irq)
`endif
    );

    seq_det_sched #(.NREQ(NREQ), .W(W), .CNT_W(1)) u_dut_sat (
        .clk(clk), .clr(clr), .req(req), .data(data), .ack(ack_s), .busy(busy_s),
        .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s), .z_mon(z_mon_s)
`ifdef SEQ_DET_IRQ_EN
        , .irq_clr(tb_irq_clr), .irq(irq_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // MSB-first bit k closes a "0110" window ending at bit k.
    function automatic bit exp_z(input logic [W-1:0] w, input int k);
        logic [W-1:0] t;
        if (k < 3 || k >= W) return 1'b0;
        t = w >> (W - 1 - k);
        return (t[3:0] == 4'b0110);
    endfunction

    function automatic int count_0110(input logic [W-1:0] w);
        int n;
        n = 0;
        for (int k = 0; k < W; k++) if (exp_z(w, k)) n++;
        return n;
    endfunction

    function automatic int sat(input int n, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        int p;
        w = W'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            p = $urandom_range(0, W - 4);
            w[p +: 4] = 4'b0110;
        end
        return w;
    endfunction

    // ---------------- scoreboard monitor ----------------
    typedef struct { int id; int cnt; } exp_t;
    exp_t            sb[$];
    int              m_phase = 0;
    int              m_last  = NREQ - 1;
    bit              m_idle  = 1'b1;
    bit              clr_prev = 1'b1;
    logic [NREQ-1:0] req_prev = '0;
    logic [W-1:0]    cur_word = '0;

    initial begin
        int ph, g;
        bit in_load;
        logic [NREQ-1:0] exp_ack;
        exp_t e;
        forever begin
            @(negedge clk);
            if (clr_prev) begin
                in_load = 1'b0;
                ph      = 0;
            end else begin
                in_load = m_idle && (req_prev != '0);
                ph      = (m_phase >= 1 && m_phase <= W + 1) ? m_phase + 1 : 0;
            end
            exp_ack = '0;
            if (in_load) begin
                g = rr_pick(m_last, req_prev);
                if (g >= 0 && req[g]) begin
                    exp_ack  = NREQ'(1) << g;
                    ph       = 1;
                    cur_word = tb_data[g];
                    sb.push_back('{g, count_0110(tb_data[g])});
                    m_last   = g;
                end
            end
            chk("ack", ack, exp_ack);
            chk("ack_sat", ack_s, exp_ack);
            chk("busy", busy, in_load || (ph != 0));
            chk("z_mon", z_mon, (ph >= 2 && ph <= W + 1) ? exp_z(cur_word, ph - 2) : 1'b0);
            chk("z_mon_sat", z_mon_s, (ph >= 2 && ph <= W + 1) ? exp_z(cur_word, ph - 2) : 1'b0);
            chk("done_timing", done, ph == W + 2);
`ifdef SEQ_DET_IRQ_EN
            chk("irq", irq, exp_irq);
`endif
            if (done) begin
                chk("sb_depth_at_done", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("match_cnt", match_cnt, sat(e.cnt, CNT_W));
                    chk("done_sat", done_s, 1);
                    chk("done_id_sat", done_id_s, e.id);
                    chk("match_cnt_sat", match_cnt_s, sat(e.cnt, 1));
`ifdef SEQ_DET_IRQ_EN
                    if (e.cnt != 0) exp_irq = 1'b1;
`endif
                end
            end
            m_phase  = ph;
            m_idle   = !in_load && (ph == 0);
            req_prev = req;
            clr_prev = clr;
            if (clr) begin
                sb.delete();
                m_last = NREQ - 1;
`ifdef SEQ_DET_IRQ_EN
                exp_irq = 1'b0;
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int i, input logic [W-1:0] w);
        int t;
        tb_data[i] = w;
        tb_req[i]  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack[i] !== 1'b1 && t < TMO);
        chk("ack_wait", t < TMO, 1);
        @(posedge clk);
        #1;
        tb_req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy !== 1'b0 && t < TMO);
        chk("idle_wait", t < TMO, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        clr = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tb_req[i]  = 1'b0;
            tb_data[i] = '0;
        end
`ifdef SEQ_DET_IRQ_EN
        tb_irq_clr = 1'b0;
`endif
        @(negedge clk);
        chk("rst_done_id", done_id, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        do_req(0, 8'b0110_0110);
        wait_idle();
        do_req(0, 8'b0110_1101);
        wait_idle();

        fork
            do_req(0, 8'h00);
            do_req(1, 8'h00);
            do_req(2, 8'h00);
            do_req(3, 8'h00);
        join
        wait_idle();

        fork
            begin repeat (4) do_req(0, rand_word()); end
            begin repeat (4) do_req(2, rand_word()); end
        join
        wait_idle();

        // clr in SHIFT bit 4 of a requester-1 frame, with 0 and 1 then pending
        fork
            do_req(1, 8'b0110_0110);
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (ack[1] !== 1'b1 && t < TMO);
                repeat (5) @(posedge clk);
                #1;
            end
        join
        clr = 1'b1;
        fork
            begin
                @(posedge clk);
                #1;
                clr = 1'b0;
                @(negedge clk);
                chk("clr_busy", busy, 0);
                chk("clr_match_cnt", match_cnt, 0);
            end
            do_req(0, 8'b0110_0000);
            do_req(1, 8'b0000_0110);
        join
        wait_idle();

        // req[1] withdrawn during LOAD: aborted grant
        tb_data[1] = 8'b0110_0110;
        tb_req[1]  = 1'b1;
        @(posedge clk);
        #1;
        tb_req[1]  = 1'b0;
        wait_idle();
        do_req(1, 8'b0110_0110);
        wait_idle();

        for (int r = 0; r < 40; r++) begin
            int mask;
            mask = $urandom_range(1, (1 << NREQ) - 1);
            for (int i = 0; i < NREQ; i++) begin
                if (mask[i]) begin
                    automatic int ii = i;
                    automatic logic [W-1:0] w = rand_word();
                    fork
                        do_req(ii, w);
                    join_none
                end
            end
            wait fork;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (W + 6) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
